// File: rtl/fc_argmax_pkg.sv
// fc_argmax_pkg: shared constants, state encoding and activation helper for fc_argmax.
package fc_argmax_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 12;

    // Activation selector value that clamps negative elements to zero
    localparam logic [4:0] ACT_RELU = 5'd1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_RESULT  = 2'd2
    } argmax_state_e;

    function automatic logic act_is_relu(input logic [4:0] act);
        return act == ACT_RELU;
    endfunction

endpackage

// File: rtl/fc_argmax_if.sv
// fc_argmax_if: element input stream, result port and (with FC_ARGMAX_PASSTHRU_EN)
// the pass-through stream of fc_argmax. slave = fc_argmax side, master = environment side.
interface fc_argmax_if
    import fc_argmax_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] din_data;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_index;
    logic [DATA_W-1:0] res_value;
`ifdef FC_ARGMAX_PASSTHRU_EN
    logic              pt_valid;
    logic              pt_ready;
    logic [DATA_W-1:0] pt_data;
`endif

    modport slave (
        input  din_valid, din_data, res_ready,
        output din_ready, res_valid, res_index, res_value
`ifdef FC_ARGMAX_PASSTHRU_EN
        , output pt_valid, pt_data
        , input  pt_ready
`endif
    );

    modport master (
        output din_valid, din_data, res_ready,
        input  din_ready, res_valid, res_index, res_value
`ifdef FC_ARGMAX_PASSTHRU_EN
        , input  pt_valid, pt_data
        , output pt_ready
`endif
    );

endinterface

// File: rtl/fc_argmax_skid_buf.sv
// fc_skid_buf: 2-entry valid/ready FIFO that forwards post-activation elements.
// Only built when FC_ARGMAX_PASSTHRU_EN is defined.
`ifdef FC_ARGMAX_PASSTHRU_EN
module fc_skid_buf #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_empty = (r_count == 2'd0);
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    // Pointer and occupancy bookkeeping; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule
`endif

// File: rtl/fc_argmax.sv
// fc_argmax: classifier tail. Applies optional ReLU to each element of a frame of cout
// values, tracks the running maximum and its lowest index, and presents {index, value}
// on a valid/ready result port. Optional feature macro: FC_ARGMAX_PASSTHRU_EN adds a
// pass-through stream of post-activation elements via fc_skid_buf.
module fc_argmax
    import fc_argmax_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cout,
    input  logic [4:0]       act_type,
    fc_argmax_if.slave       bus
);
    argmax_state_e     r_state;
    argmax_state_e     w_state_nxt;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] w_v;
    logic              w_din_ready;
    logic              w_res_valid;
    logic              w_accept;
    logic              w_last;
    logic              w_take;
    logic              w_buf_room;
    logic              w_buf_empty;

    assign w_v      = (act_is_relu(act_type) && bus.din_data[DATA_W-1]) ? '0 : bus.din_data;
    assign w_accept = bus.din_valid & w_din_ready;
    assign w_last   = (r_cnt == r_len - CNT_W'(1));
    assign w_take   = (r_cnt == '0) || ($signed(w_v) > $signed(r_max));

`ifdef FC_ARGMAX_PASSTHRU_EN
    fc_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_accept),
        .o_ready (w_buf_room),
        .i_data  (w_v),
        .o_valid (bus.pt_valid),
        .i_ready (bus.pt_ready),
        .o_data  (bus.pt_data),
        .o_empty (w_buf_empty)
    );
`else
    assign w_buf_room  = 1'b1;
    assign w_buf_empty = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs; the collect exit uses din_valid directly to keep
    // din_ready out of its own fan-in
    always_comb begin
        w_state_nxt = r_state;
        w_din_ready = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cout != '0) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                w_din_ready = w_buf_room;
                if (bus.din_valid && w_buf_room && w_last) w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                w_res_valid = w_buf_empty;
                if (w_buf_empty && bus.res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame length latch, element counter and running max/index tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cnt <= '0;
            r_idx <= '0;
            r_max <= '0;
        end else begin
            if (r_state == S_IDLE && cout != '0) r_len <= cout;
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_take) begin
                    r_max <= w_v;
                    r_idx <= r_cnt;
                end
            end
            if (w_res_valid && bus.res_ready) r_cnt <= '0;
        end
    end

    assign bus.din_ready = w_din_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.res_index = r_idx;
    assign bus.res_value = r_max;

endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: directed self-checking bench for fc_argmax.
module tb_fc_argmax;
    import fc_argmax_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cout = '0;
    logic [4:0]  act_type = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fc_argmax_if bus ();

    fc_argmax dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cout     (cout),
        .act_type (act_type),
        .bus      (bus)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one element and hold it until accepted (bounded); returns #1 after the accept edge
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        bus.din_valid = 1'b1;
        bus.din_data  = d;
        while (bus.din_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("din_ready_timeout", {31'd0, bus.din_ready}, 32'd1);
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
    endtask

    // Result check, taken right after the final accept
    task automatic check_result(input string tag, input logic [11:0] idx, input logic [15:0] val);
`ifdef FC_ARGMAX_PASSTHRU_EN
        @(posedge clk); #1;
`endif
        chk({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd1);
        chk({tag, "_index"}, {20'd0, bus.res_index}, {20'd0, idx});
        chk({tag, "_value"}, {16'd0, bus.res_value}, {16'd0, val});
    endtask

    task automatic consume();
        cout = '0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
        chk("din_ready_idle", {31'd0, bus.din_ready}, 32'd0);
    endtask

    initial begin
        bus.din_valid = 1'b0;
        bus.din_data  = '0;
        bus.res_ready = 1'b0;
`ifdef FC_ARGMAX_PASSTHRU_EN
        bus.pt_ready  = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din_ready", {31'd0, bus.din_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_index", {20'd0, bus.res_index}, 32'd0);
        chk("rst_res_value", {16'd0, bus.res_value}, 32'd0);
        rst_n = 1'b1;

        // cout==0: stays idle, no data taken
        bus.din_valid = 1'b1;
        bus.din_data  = 16'h7777;
        repeat (3) @(posedge clk);
        #1;
        chk("cout0_din_ready", {31'd0, bus.din_ready}, 32'd0);
        bus.din_valid = 1'b0;

        // Test 1: basic max
        cout = 12'd4;
        send(16'h0400); send(16'hFC00); send(16'h0C00); send(16'h0800);
        check_result("t1", 12'd2, 16'h0C00);
        consume();

        // Test 2: ties keep the lowest index
        cout = 12'd3;
        send(16'hF000); send(16'hF000); send(16'hF000);
        check_result("t2", 12'd0, 16'hF000);
        consume();

        // Test 3: ReLU clamps all-negative frame to zero
        cout = 12'd3;
        act_type = ACT_RELU;
        send(16'hF000); send(16'hE000); send(16'h8000);
        check_result("t3", 12'd0, 16'h0000);
        consume();

        // Mid-frame act change and cout change
        cout = 12'd3;
        act_type = 5'd0;
        send(16'hFF00);
        act_type = ACT_RELU;
        cout = 12'd7;
        send(16'hF000); send(16'h0000);
        check_result("midchg", 12'd1, 16'h0000);
        act_type = 5'd0;
        consume();

        // Test 4: result held under backpressure
        cout = 12'd2;
        send(16'h0100); send(16'h0200);
        check_result("t4", 12'd1, 16'h0200);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("t4_hold_index", {20'd0, bus.res_index}, 32'd1);
            chk("t4_hold_value", {16'd0, bus.res_value}, 32'h0200);
            chk("t4_hold_dinrdy", {31'd0, bus.din_ready}, 32'd0);
        end
        cout = 12'd3;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("t4_release", {31'd0, bus.res_valid}, 32'd0);
        send(16'h7FFF); send(16'h8000); send(16'h7FFF);
        check_result("t4_next", 12'd0, 16'h7FFF);
        consume();

        // Test 5: reset mid-frame discards the partial frame
        cout = 12'd8;
        send(16'h0001); send(16'h0005); send(16'h0003);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_din_ready", {31'd0, bus.din_ready}, 32'd0);
        chk("t5_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t5_rst_res_index", {20'd0, bus.res_index}, 32'd0);
        chk("t5_rst_res_value", {16'd0, bus.res_value}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(16'h0001); send(16'h0005); send(16'h0003); send(16'h0005);
        send(16'hFFFE); send(16'h0009); send(16'h0009); send(16'h0000);
        check_result("t5", 12'd5, 16'h0009);
        consume();

`ifdef FC_ARGMAX_PASSTHRU_EN
        // Test 6: pass-through order, buffer-full backpressure, result after last drain
        begin
            logic [15:0] exp_pt [5];
            int          got;
            int          acc;
            exp_pt[0] = 16'h0100; exp_pt[1] = 16'hF800; exp_pt[2] = 16'h0300;
            exp_pt[3] = 16'h0200; exp_pt[4] = 16'h0050;
            got = 0;
            acc = 0;
            cout = 12'd5;
            fork
                begin
                    for (int k = 0; k < 5; k++) send(exp_pt[k]);
                end
                begin
                    for (int c = 0; c < 100 && got < 5; c++) begin
                        @(negedge clk);
                        if (acc - got == 2) chk("t6_full_dinrdy", {31'd0, bus.din_ready}, 32'd0);
                        chk("t6_res_early", {31'd0, bus.res_valid}, 32'd0);
                        if (bus.pt_valid && bus.pt_ready) begin
                            chk("t6_pt_data", {16'd0, bus.pt_data}, {16'd0, exp_pt[got]});
                            got++;
                        end
                        if (bus.din_valid && bus.din_ready) acc++;
                        bus.pt_ready = ~bus.pt_ready;
                    end
                end
            join
            chk("t6_pt_count", got, 32'd5);
            bus.pt_ready = 1'b1;
            @(posedge clk); #1;
            chk("t6_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("t6_index", {20'd0, bus.res_index}, 32'd2);
            chk("t6_value", {16'd0, bus.res_value}, 32'h0300);
            consume();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
